// File: rtl/uart_rx_buffer.sv
// Receive-side byte FIFO: UART strobes in, valid/ready out, sticky overflow and saturating drop count.
// Define UART_RX_EOL_FILTER_EN to fold CR and CRLF line endings into a single LF.
module uart_rx_buffer #(
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_valid,
  output logic [7:0]            o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_overflow,
  input  logic                  i_clr_ovf,
  output logic [7:0]            o_drop_cnt
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]         count;

  logic       push_req;
  logic [7:0] push_byte;
  logic       pop, accept, drop, full;

`ifdef UART_RX_EOL_FILTER_EN
  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;

  typedef enum logic {IDLE, SAW_CR} filt_state_t;
  filt_state_t state, state_next;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Advances on every strobe regardless of whether the FIFO can take the byte.
  always_comb begin
    state_next = state;
    push_req   = 1'b0;
    push_byte  = i_rx_data;
    if (i_rx_valid) begin
      case (state)
        IDLE: begin
          push_req = 1'b1;
          if (i_rx_data == CR) begin
            push_byte  = LF;
            state_next = SAW_CR;
          end
        end
        SAW_CR: begin
          if (i_rx_data == LF) begin
            state_next = IDLE;
          end else if (i_rx_data == CR) begin
            push_req  = 1'b1;
            push_byte = LF;
          end else begin
            push_req   = 1'b1;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end
`else
  always_comb begin
    push_req  = i_rx_valid;
    push_byte = i_rx_data;
  end
`endif

  always_comb begin
    full   = (count == FULL_CNT);
    pop    = (count != '0) && i_ready;
    // A pop in the same edge frees the slot, so a full FIFO still accepts.
    accept = push_req && (!full || pop);
    drop   = push_req && full && !pop;
  end

  always_ff @(posedge clk) begin
    if (!rst && accept) mem[wr_ptr] <= push_byte;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (pop)    rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      case ({accept, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // A drop in the same edge as a clear wins: the counter restarts at one.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_overflow <= 1'b0;
      o_drop_cnt <= '0;
    end else if (drop) begin
      o_overflow <= 1'b1;
      if (i_clr_ovf)                o_drop_cnt <= 8'd1;
      else if (o_drop_cnt != 8'hFF) o_drop_cnt <= o_drop_cnt + 8'd1;
    end else if (i_clr_ovf) begin
      o_overflow <= 1'b0;
      o_drop_cnt <= '0;
    end
  end

  always_comb begin
    o_count = count;
    o_full  = full;
    o_empty = (count == '0);
    o_valid = (count != '0);
    o_data  = o_valid ? mem[rd_ptr] : 8'h00;
  end

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed bench for uart_rx_buffer (DEPTH_LOG2=3); expectations follow UART_RX_EOL_FILTER_EN when defined.
module tb_uart_rx_buffer;

  logic       clk;
  logic       rst;
  logic [7:0] i_rx_data;
  logic       i_rx_valid;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;
  logic [3:0] o_count;
  logic       o_full;
  logic       o_empty;
  logic       o_overflow;
  logic       i_clr_ovf;
  logic [7:0] o_drop_cnt;

  uart_rx_buffer #(.DEPTH_LOG2(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_rx_data  (i_rx_data),
    .i_rx_valid (i_rx_valid),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_count    (o_count),
    .o_full     (o_full),
    .o_empty    (o_empty),
    .o_overflow (o_overflow),
    .i_clr_ovf  (i_clr_ovf),
    .o_drop_cnt (o_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic       rst;
    logic       v;
    logic [7:0] d;
    logic       rdy;
    logic       clr;
    int         cnt;
    logic [7:0] data;
    logic       ovf;
    int         drop;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  function automatic void add(input string tag, input logic r, input logic v, input logic [7:0] d,
                              input logic rdy, input logic clr, input int cnt, input logic [7:0] data,
                              input logic ovf, input int drop);
    vec_t e;
    e.tag = tag; e.rst = r; e.v = v; e.d = d; e.rdy = rdy; e.clr = clr;
    e.cnt = cnt; e.data = data; e.ovf = ovf; e.drop = drop;
    vecs.push_back(e);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [7:0] d, input logic rdy, input logic clr);
    rst = r; i_rx_valid = v; i_rx_data = d; i_ready = rdy; i_clr_ovf = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string name, input int cnt, input logic [7:0] data,
                           input logic ovf, input int drop);
    chk({name, ".count"},    32'(o_count),    32'(cnt));
    chk({name, ".valid"},    32'(o_valid),    32'(cnt != 0));
    chk({name, ".empty"},    32'(o_empty),    32'(cnt == 0));
    chk({name, ".full"},     32'(o_full),     32'(cnt == 8));
    chk({name, ".data"},     32'(o_data),     32'(data));
    chk({name, ".overflow"}, 32'(o_overflow), 32'(ovf));
    chk({name, ".drop_cnt"}, 32'(o_drop_cnt), 32'(drop));
  endtask

  logic [7:0] eol_in [7];
`ifdef UART_RX_EOL_FILTER_EN
  localparam int EOL_N = 6;
  logic [7:0] eol_out [EOL_N];
  int         eol_cnt [7];
`else
  localparam int EOL_N = 7;
  logic [7:0] eol_out [EOL_N];
  int         eol_cnt [7];
`endif

  initial begin
    rst = 1'b0; i_rx_valid = 1'b0; i_rx_data = 8'h00; i_ready = 1'b0; i_clr_ovf = 1'b0;

    eol_in = '{8'h41, 8'h0D, 8'h0A, 8'h42, 8'h0A, 8'h0D, 8'h0D};
`ifdef UART_RX_EOL_FILTER_EN
    eol_out = '{8'h41, 8'h0A, 8'h42, 8'h0A, 8'h0A, 8'h0A};
    eol_cnt = '{1, 2, 2, 3, 4, 5, 6};
`else
    eol_out = '{8'h41, 8'h0D, 8'h0A, 8'h42, 8'h0A, 8'h0D, 8'h0D};
    eol_cnt = '{1, 2, 3, 4, 5, 6, 7};
`endif

    //    tag          rst v  d      rdy clr cnt data   ovf drop
    add("reset",       1, 0, 8'h00, 0, 0,  0, 8'h00, 0, 0);
    add("t1_push",     0, 1, 8'h77, 0, 0,  1, 8'h77, 0, 0);
    add("t1_push",     0, 1, 8'h61, 0, 0,  2, 8'h77, 0, 0);
    add("t1_push",     0, 1, 8'h73, 0, 0,  3, 8'h77, 0, 0);
    add("t1_push",     0, 1, 8'h64, 0, 0,  4, 8'h77, 0, 0);
    add("t1_pop",      0, 0, 8'h00, 1, 0,  3, 8'h61, 0, 0);
    add("t1_pop",      0, 0, 8'h00, 1, 0,  2, 8'h73, 0, 0);
    add("t1_pop",      0, 0, 8'h00, 1, 0,  1, 8'h64, 0, 0);
    add("t1_pop",      0, 0, 8'h00, 1, 0,  0, 8'h00, 0, 0);
    add("t1_idle_rdy0",0, 0, 8'h00, 0, 0,  0, 8'h00, 0, 0);

    for (int i = 0; i < 8; i++) add("t2_fill", 0, 1, 8'(i), 0, 0, i + 1, 8'h00, 0, 0);
    add("t2_drop",     0, 1, 8'h08, 0, 0,  8, 8'h00, 1, 1);
    add("t2_drop",     0, 1, 8'h09, 0, 0,  8, 8'h00, 1, 2);
    for (int k = 1; k <= 8; k++)
      add("t2_drain", 0, 0, 8'h00, 1, 0, 8 - k, (k < 8) ? 8'(k) : 8'h00, 1, 2);
    add("t2_clr",      0, 0, 8'h00, 0, 1,  0, 8'h00, 0, 0);

    for (int i = 0; i < 8; i++) add("t3_fill", 0, 1, 8'(i), 0, 0, i + 1, 8'h00, 0, 0);
    add("t3_full_pushpop", 0, 1, 8'hAA, 1, 0, 8, 8'h01, 0, 0);
    for (int k = 1; k <= 8; k++)
      add("t3_drain", 0, 0, 8'h00, 1, 0, 8 - k,
          (k < 7) ? 8'(k + 1) : ((k == 7) ? 8'hAA : 8'h00), 0, 0);

    for (int i = 0; i < 7; i++) add("t5_eol_push", 0, 1, eol_in[i], 0, 0, eol_cnt[i], 8'h41, 0, 0);
    for (int j = 1; j <= EOL_N; j++)
      add("t5_eol_drain", 0, 0, 8'h00, 1, 0, EOL_N - j, (j < EOL_N) ? eol_out[j] : 8'h00, 0, 0);

    for (int i = 0; i < 8; i++) add("t7_fill", 0, 1, 8'(8'h20 + i), 0, 0, i + 1, 8'h20, 0, 0);
    add("t7_drop",     0, 1, 8'h28, 0, 0,  8, 8'h20, 1, 1);
    add("t7_drop_clr", 0, 1, 8'h29, 0, 1,  8, 8'h20, 1, 1);
    for (int k = 1; k <= 256; k++)
      add("t7_sat", 0, 1, 8'h30, 0, 0, 8, 8'h20, 1, (k + 1 > 255) ? 255 : k + 1);
    add("t7_rst_full", 1, 1, 8'h31, 0, 0, 0, 8'h00, 0, 0);

    add("t6_fill",     0, 1, 8'h11, 0, 0,  1, 8'h11, 0, 0);
    add("t6_fill",     0, 1, 8'h12, 0, 0,  2, 8'h11, 0, 0);
    add("t6_fill",     0, 1, 8'h13, 0, 0,  3, 8'h11, 0, 0);
    add("t6_fill",     0, 1, 8'h14, 0, 0,  4, 8'h11, 0, 0);
    add("t6_fill",     0, 1, 8'h0D, 0, 0,  5, 8'h11, 0, 0);
    add("t6_rst_strb", 1, 1, 8'h99, 0, 0,  0, 8'h00, 0, 0);
    add("t6_after",    0, 1, 8'h33, 0, 0,  1, 8'h33, 0, 0);
    add("t6_lf",       0, 1, 8'h0A, 0, 0,  2, 8'h33, 0, 0);
    add("t6_pop",      0, 0, 8'h00, 1, 0,  1, 8'h0A, 0, 0);
    add("t6_pop",      0, 0, 8'h00, 1, 0,  0, 8'h00, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].v, vecs[i].d, vecs[i].rdy, vecs[i].clr);
      chk_state($sformatf("%s[%0d]", vecs[i].tag, i), vecs[i].cnt, vecs[i].data, vecs[i].ovf, vecs[i].drop);
    end

    // Empty FIFO with consumer always ready: the byte is visible for exactly one cycle.
    drive(0, 1, 8'h55, 1, 0);
    chk_state("t4_single_strobe", 1, 8'h55, 0, 0);
    drive(0, 0, 8'h00, 1, 0);
    chk_state("t4_popped", 0, 8'h00, 0, 0);
    drive(0, 0, 8'h00, 1, 0);
    chk_state("t4_stays_empty", 0, 8'h00, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_buffer.md
Name: uart_rx_buffer

Overview:
Receive-side counterpart of the UART transmit front end. Captures single-cycle byte strobes from the UART core's receive outputs into an internal FIFO. Presents the bytes to the game logic over a valid/ready interface. Flags overflow with a sticky bit and counts dropped bytes.

Parameters:
DEPTH_LOG2, 3, log2 of FIFO depth (default 8 entries); legal range 1..8.

Ports:
clk  input  1  system clock
rst  input  1  reset; synchronous, active-high
i_rx_data  input  8  received byte from UART core
i_rx_valid  input  1  one-cycle strobe; i_rx_data is valid in that cycle
o_data  output  8  head-of-FIFO byte; 0x00 whenever o_valid=0
o_valid  output  1  FIFO non-empty
i_ready  input  1  consumer accepts o_data; pop = o_valid & i_ready
o_count  output  DEPTH_LOG2+1  current occupancy, 0..2^DEPTH_LOG2
o_full  output  1  o_count == 2^DEPTH_LOG2
o_empty  output  1  o_count == 0
o_overflow  output  1  sticky; a byte was dropped
i_clr_ovf  input  1  clears o_overflow and o_drop_cnt
o_drop_cnt  output  8  number of dropped bytes; saturates at 0xFF

Behaviour:
- Reset (clk edge with rst=1) sets the following; memory contents are not reset:
  - o_valid=0, o_empty=1, o_full=0, o_count=0, o_data=0x00.
  - o_overflow=0, o_drop_cnt=0.
  - Read and write pointers = 0; filter FSM = IDLE.
- Reset mid-operation discards all stored bytes. An i_rx_valid in the reset cycle is ignored.
- Push: a byte sampled with i_rx_valid=1 at edge N gives o_valid=1 and o_data=byte after edge N. Latency is 1 cycle; there is no bypass when empty.
- Pop: when o_valid & i_ready at an edge, the read pointer advances. i_ready is ignored while o_valid=0.
- Pointers are DEPTH_LOG2 bits and wrap modulo depth. o_count is tracked separately:
  - push only: +1
  - pop only: -1
  - both, or neither: unchanged
- Full and push without pop: the byte is dropped; o_overflow<=1; o_drop_cnt increments, saturating at 0xFF.
- Full and push with pop in the same edge: the push is accepted and count stays at full. This is not an overflow.
- Empty and push with i_ready=1: the byte is stored, no pop occurs, and count becomes 1.
- i_clr_ovf=1 clears o_overflow and o_drop_cnt. If a drop occurs in the same edge, the drop wins: o_overflow=1 and o_drop_cnt=1.
- Filter FSM with states IDLE and SAW_CR. It sits between the input strobe and the FIFO push, adds no latency, and is only active with the macro below. Without the macro the FSM stays in IDLE and every byte is pushed unchanged.

Optional Feature:
Macro UART_RX_EOL_FILTER_EN normalises line endings; with it defined the filter FSM runs as follows:
- IDLE, byte 0x0D: push 0x0A, go to SAW_CR.
- IDLE, byte 0x0A: push 0x0A, stay in IDLE.
- IDLE, other byte: push the byte, stay in IDLE.
- SAW_CR, byte 0x0A: push nothing, go to IDLE.
- SAW_CR, byte 0x0D: push 0x0A, stay in SAW_CR.
- SAW_CR, other byte: push the byte, go to IDLE.
- The FSM advances even when the push is dropped for overflow.

Without the macro, bytes pass through unchanged and the FSM logic is not compiled.

Test Plan:
- Reset, then strobe 0x77, 0x61, 0x73, 0x64 with i_ready=0 -> o_count=4, o_data=0x77. Then i_ready=1 for 4 cycles -> pops in order 0x77, 0x61, 0x73, 0x64; o_empty=1 and o_data=0x00 afterwards.
- DEPTH_LOG2=3, i_ready=0, 10 strobes of 0x00..0x09 -> o_full=1, o_count=8, o_overflow=1, o_drop_cnt=2. Draining yields 0x00..0x07. Then pulse i_clr_ovf -> o_overflow=0, o_drop_cnt=0.
- Fill to 8, then in one cycle strobe 0xAA with i_ready=1 -> o_count stays 8, no overflow. Drain order is 0x01..0x07 then 0xAA, with wrap-around verified.
- Empty FIFO, i_ready held 1, single strobe 0x55 -> o_valid high for exactly one cycle with o_data=0x55, then o_empty=1.
- With UART_RX_EOL_FILTER_EN, strobe 0x41, 0x0D, 0x0A, 0x42, 0x0A, 0x0D, 0x0D -> FIFO holds 0x41, 0x0A, 0x42, 0x0A, 0x0A, 0x0A (o_count=6). Without the macro -> 7 bytes, unchanged.
- Fill 5 bytes, assert rst for one cycle together with a strobe -> o_count=0, o_valid=0, o_overflow=0. The next strobe 0x33 appears at the head.
